eco32f_rf_scoreboard: RTL and testbench
=======================================

Name: eco32f_rf_scoreboard

Overview:
Controls access to the register file for long-latency multiply/divide (MDU) results. It keeps a per-register busy scoreboard and generates the ID-stage interlock for RAW and WAW hazards on pending MDU destinations. It also arbitrates the single RF write port between pipeline writeback and a one-entry MDU result holding buffer. It sits between the WB stage, the MDU and the register file write port, and adds to id_stall.

Parameters:
MDU_DEPTH, 1, maximum outstanding MDU operations (1..3).
STARVE_LIMIT, 4, consecutive cycles a valid hold entry may lose arbitration before wb_freeze asserts (1..15).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
id_valid  in  1  ID holds a valid instruction
id_issue  in  1  ID instruction advances to EX this cycle
id_mdu_op  in  1  ID instruction is an MDU op
id_rf_x_addr  in  5  ID source X
id_rf_x_re  in  1  source X used
id_rf_y_addr  in  5  ID source Y
id_rf_y_re  in  1  source Y used
id_rf_r_addr  in  5  ID destination
id_rf_r_we  in  1  ID writes destination
sb_stall  out  1  interlock request, ORed into id_stall
wb_rf_r_addr  in  5  pipeline writeback address
wb_rf_r_we  in  1  pipeline writeback enable
wb_rf_r  in  32  pipeline writeback data
wb_freeze  out  1  WB must not retire this cycle (hold-entry starvation)
mdu_done  in  1  MDU result valid
mdu_rf_r_addr  in  5  MDU result destination
mdu_result  in  32  MDU result data
mdu_ack  out  1  result accepted this cycle
rf_waddr  out  5  RF write address
rf_we  out  1  RF write enable
rf_wdata  out  32  RF write data

Behaviour:
- Reset (rst=0, async): busy[31:0]=0, outstanding=0, hold_valid=0, starve_cnt=0. Outputs: sb_stall=0, mdu_ack=1, wb_freeze=0, rf_we=0, rf_waddr=0, rf_wdata=0. A reset mid-operation discards pending results; busy bits are not cleared by writes.
- Scoreboard set: id_issue & id_mdu_op & id_rf_r_we & id_rf_r_addr!=0 -> busy[id_rf_r_addr]<=1 and outstanding++. busy[0] is never set.
- Scoreboard clear: when the hold entry writes the RF -> busy[hold_addr]<=0 and outstanding--. A simultaneous set and clear of the same address leaves the bit set. A simultaneous increment and decrement leaves outstanding unchanged.
- sb_stall (combinational) = id_valid & ((id_rf_x_re & busy[x]) | (id_rf_y_re & busy[y]) | (id_rf_r_we & busy[r]) | (id_mdu_op & outstanding==MDU_DEPTH)). Address 0 never stalls.
- The interlock releases on the cycle after the hold write. The RF RAM bypass covers a same-cycle read.
- Hold buffer: mdu_ack = !hold_valid (combinational). mdu_done & mdu_ack -> capture addr/data and set hold_valid on the next edge. The MDU keeps mdu_done and its data stable until acked.
- Write port mux (combinational), in priority order:
  - wb_rf_r_we & !wb_freeze -> pipeline write.
  - else hold_valid -> hold write; hold_valid clears on the next edge.
  - else rf_we=0.
- MDU-to-RF latency is 2 edges minimum: capture, then write.
- Starvation: starve_cnt increments each cycle with hold_valid & wb_rf_r_we & !wb_freeze; it clears on a hold write or when !hold_valid.
  - wb_freeze = hold_valid & starve_cnt>=STARVE_LIMIT (registered compare). That cycle the hold entry writes and the pipeline holds WB.
  - wb_freeze never asserts when hold_valid=0.
- An MDU result to address 0 is captured and acked. It asserts no rf_we and clears nothing.
- ID flushes do not affect issued MDU ops. MDU ops issue only when non-speculative.

Test Plan:
- MDU op with dest r5 issues, then ID reads r5 on x -> sb_stall=1 until mdu_done; ack at T, rf_we=1 addr 5 at T+1, sb_stall=0 at T+2; ID reading r6 never stalls.
- WAW: MDU to r7 pending, ALU op with dest r7 in ID -> sb_stall=1; after the r7 hold write -> 0. With MDU_DEPTH=1, a second MDU op stalls until outstanding=0.
- Contention: hold_valid with wb_rf_r_we=1 every cycle -> pipeline writes 4 cycles, wb_freeze=1 on the 5th; hold writes addr/data 0xDEADBEEF; starve_cnt resets.
- Back-to-back mdu_done while hold_valid -> mdu_ack=0, data held; ack the cycle after the hold drains; busy bit and outstanding are correct after both writes.
- Assert rst low mid-hold with busy[3]=1 -> immediately busy=0, hold_valid=0, rf_we=0, mdu_ack=1; ID reading r3 after release does not stall.
- MDU result for r0 and ID reading r0 -> no stall, rf_we=0, mdu_ack pulses normally.

Source files
------------

// File: rtl/eco32f_rf_scoreboard.sv
// rtl/eco32f_rf_scoreboard.sv - MDU busy scoreboard, ID interlock and RF write-port arbiter
module eco32f_rf_scoreboard #(
  parameter int unsigned MDU_DEPTH    = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  input  logic        id_issue_i,
  input  logic        id_mdu_op_i,
  input  logic [4:0]  id_rf_x_addr_i,
  input  logic        id_rf_x_re_i,
  input  logic [4:0]  id_rf_y_addr_i,
  input  logic        id_rf_y_re_i,
  input  logic [4:0]  id_rf_r_addr_i,
  input  logic        id_rf_r_we_i,
  output logic        sb_stall_o,
  input  logic [4:0]  wb_rf_r_addr_i,
  input  logic        wb_rf_r_we_i,
  input  logic [31:0] wb_rf_r_i,
  output logic        wb_freeze_o,
  input  logic        mdu_done_i,
  input  logic [4:0]  mdu_rf_r_addr_i,
  input  logic [31:0] mdu_result_i,
  output logic        mdu_ack_o,
  output logic [4:0]  rf_waddr_o,
  output logic        rf_we_o,
  output logic [31:0] rf_wdata_o
);

  localparam logic [1:0] DEPTH_C = 2'(MDU_DEPTH);
  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [31:0] busy_q, busy_d;
  logic [1:0]  outst_q, outst_d;
  logic        hold_valid_q, hold_valid_d;
  logic [4:0]  hold_addr_q, hold_addr_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [3:0]  starve_q, starve_d;

  logic freeze;
  logic pipe_wr;
  logic hold_sel;
  logic sb_set;
  logic sb_clr;
  logic ack;

  // Write-port arbitration, interlock and output muxing.
  always_comb begin
    freeze   = hold_valid_q & (starve_q >= LIMIT_C);
    pipe_wr  = wb_rf_r_we_i & ~freeze;
    // The hold entry owns the slot whenever the pipeline does not write;
    // an r0 result consumes the slot without touching the RF.
    hold_sel = hold_valid_q & ~pipe_wr;
    sb_clr   = hold_sel & (hold_addr_q != 5'd0);
    sb_set   = id_issue_i & id_mdu_op_i & id_rf_r_we_i & (id_rf_r_addr_i != 5'd0);
    ack      = ~hold_valid_q;

    sb_stall_o  = id_valid_i & ((id_rf_x_re_i & busy_q[id_rf_x_addr_i]) |
                                (id_rf_y_re_i & busy_q[id_rf_y_addr_i]) |
                                (id_rf_r_we_i & busy_q[id_rf_r_addr_i]) |
                                (id_mdu_op_i  & (outst_q == DEPTH_C)));
    wb_freeze_o = freeze;
    mdu_ack_o   = ack;

    rf_we_o    = pipe_wr | sb_clr;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (pipe_wr) begin
      rf_waddr_o = wb_rf_r_addr_i;
      rf_wdata_o = wb_rf_r_i;
    end else if (sb_clr) begin
      rf_waddr_o = hold_addr_q;
      rf_wdata_o = hold_data_q;
    end
  end

  // Next state for scoreboard, outstanding count, hold entry and starvation counter.
  always_comb begin
    busy_d = busy_q;
    if (sb_clr) busy_d[hold_addr_q] = 1'b0;
    // Set after clear so a same-address set/clear leaves the bit set.
    if (sb_set) busy_d[id_rf_r_addr_i] = 1'b1;
    busy_d[0] = 1'b0;

    outst_d = outst_q + {1'b0, sb_set} - {1'b0, sb_clr};

    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    if (hold_sel) begin
      hold_valid_d = 1'b0;
    end else if (mdu_done_i & ack) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = mdu_rf_r_addr_i;
      hold_data_d  = mdu_result_i;
    end

    starve_d = starve_q;
    if (!hold_valid_q || hold_sel) begin
      starve_d = 4'd0;
    end else if (pipe_wr) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers; reset discards any pending MDU result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q       <= 32'd0;
      outst_q      <= 2'd0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= 5'd0;
      hold_data_q  <= 32'd0;
      starve_q     <= 4'd0;
    end else begin
      busy_q       <= busy_d;
      outst_q      <= outst_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      starve_q     <= starve_d;
    end
  end

endmodule

// File: tb/tb_eco32f_rf_scoreboard.sv
// tb/tb_eco32f_rf_scoreboard.sv - directed vector bench for eco32f_rf_scoreboard
module tb_eco32f_rf_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        id_valid, id_issue, id_mdu_op;
  logic [4:0]  id_x, id_y, id_r;
  logic        id_x_re, id_y_re, id_r_we;
  logic [4:0]  wb_addr;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        mdu_done;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;

  logic        sb_stall, wb_freeze, mdu_ack, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_stall2, wb_freeze2, mdu_ack2, rf_we2;
  logic [4:0]  rf_waddr2;
  logic [31:0] rf_wdata2;

  int cmp_cnt = 0;
  int err_cnt = 0;

  eco32f_rf_scoreboard #(.MDU_DEPTH(1), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_issue_i(id_issue), .id_mdu_op_i(id_mdu_op),
    .id_rf_x_addr_i(id_x), .id_rf_x_re_i(id_x_re),
    .id_rf_y_addr_i(id_y), .id_rf_y_re_i(id_y_re),
    .id_rf_r_addr_i(id_r), .id_rf_r_we_i(id_r_we),
    .sb_stall_o(sb_stall),
    .wb_rf_r_addr_i(wb_addr), .wb_rf_r_we_i(wb_we), .wb_rf_r_i(wb_data),
    .wb_freeze_o(wb_freeze),
    .mdu_done_i(mdu_done), .mdu_rf_r_addr_i(mdu_addr), .mdu_result_i(mdu_data),
    .mdu_ack_o(mdu_ack),
    .rf_waddr_o(rf_waddr), .rf_we_o(rf_we), .rf_wdata_o(rf_wdata)
  );

  eco32f_rf_scoreboard #(.MDU_DEPTH(2), .STARVE_LIMIT(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_issue_i(id_issue), .id_mdu_op_i(id_mdu_op),
    .id_rf_x_addr_i(id_x), .id_rf_x_re_i(id_x_re),
    .id_rf_y_addr_i(id_y), .id_rf_y_re_i(id_y_re),
    .id_rf_r_addr_i(id_r), .id_rf_r_we_i(id_r_we),
    .sb_stall_o(sb_stall2),
    .wb_rf_r_addr_i(wb_addr), .wb_rf_r_we_i(wb_we), .wb_rf_r_i(wb_data),
    .wb_freeze_o(wb_freeze2),
    .mdu_done_i(mdu_done), .mdu_rf_r_addr_i(mdu_addr), .mdu_result_i(mdu_data),
    .mdu_ack_o(mdu_ack2),
    .rf_waddr_o(rf_waddr2), .rf_we_o(rf_we2), .rf_wdata_o(rf_wdata2)
  );

  typedef struct {
    logic [31:0] iv, iss, mdu, xa, xre, ya, yre, ra, rwe;
    logic [31:0] wbwe, wba, wbd;
    logic [31:0] md, ma, mdd;
    logic [31:0] st, ack, frz, we, wa, wd;
  } vec_t;

  vec_t tv[$];

  task automatic chk1(input string nm, input logic act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp[0]) begin
      err_cnt++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp[0]);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    id_valid = 1'b0; id_issue = 1'b0; id_mdu_op = 1'b0;
    id_x = 5'd0; id_y = 5'd0; id_r = 5'd0;
    id_x_re = 1'b0; id_y_re = 1'b0; id_r_we = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    mdu_done = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.iv[0]; id_issue = v.iss[0]; id_mdu_op = v.mdu[0];
    id_x = v.xa[4:0]; id_x_re = v.xre[0];
    id_y = v.ya[4:0]; id_y_re = v.yre[0];
    id_r = v.ra[4:0]; id_r_we = v.rwe[0];
    wb_we = v.wbwe[0]; wb_addr = v.wba[4:0]; wb_data = v.wbd;
    mdu_done = v.md[0]; mdu_addr = v.ma[4:0]; mdu_data = v.mdd;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk1($sformatf("v%0d.sb_stall", i), sb_stall, v.st);
    chk1($sformatf("v%0d.mdu_ack", i), mdu_ack, v.ack);
    chk1($sformatf("v%0d.wb_freeze", i), wb_freeze, v.frz);
    chk1($sformatf("v%0d.rf_we", i), rf_we, v.we);
    chk32($sformatf("v%0d.rf_waddr", i), {27'd0, rf_waddr}, v.wa);
    chk32($sformatf("v%0d.rf_wdata", i), rf_wdata, v.wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clr_in();

    //                iv iss mdu xa xre ya yre ra rwe  wbwe wba wbd           md ma mdd            st ack frz we wa wd
    tv.push_back(vec_t'{0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 1, 1,  0, 0,  0, 0,  5, 1,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  5, 1,  0, 0,  0, 0,  0,  0, 0,            0, 0, 0,             1, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{0, 0, 0,  5, 1,  0, 0,  0, 0,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  6, 1,  6, 1,  0, 0,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  0, 0,  5, 1,  0, 0,  0,  0, 0,            0, 0, 0,             1, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  5, 0,  5, 0,  5, 0,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 1,  0, 0,  0, 0,  9, 1,  0,  0, 0,            0, 0, 0,             1, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  5, 1,  0, 0,  0, 0,  0,  0, 0,            1, 5, 32'h12345678,  1, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  5, 1,  0, 0,  0, 0,  0,  0, 0,            0, 0, 0,             1, 0, 0, 1, 5, 32'h12345678});
    tv.push_back(vec_t'{1, 0, 0,  5, 1,  0, 0,  0, 0,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 1, 1,  0, 0,  0, 0,  7, 1,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  0, 0,  0, 0,  7, 1,  0,  0, 0,            0, 0, 0,             1, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  0, 0,  0, 0,  7, 1,  1,  2, 32'hAAAA0001, 1, 7, 32'h00007777,  1, 1, 0, 1, 2, 32'hAAAA0001});
    tv.push_back(vec_t'{1, 0, 0,  0, 0,  0, 0,  7, 1,  0,  0, 0,            0, 0, 0,             1, 0, 0, 1, 7, 32'h00007777});
    tv.push_back(vec_t'{1, 0, 0,  0, 0,  0, 0,  7, 1,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  0, 1,  0, 1,  0, 1,  0,  0, 0,            1, 0, 32'h0000FFFF,  0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  0, 1,  0, 1,  0, 1,  0,  0, 0,            0, 0, 0,             0, 0, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 0,  0, 1,  0, 1,  0, 1,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 1, 1,  0, 0,  0, 0,  0, 1,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});
    tv.push_back(vec_t'{1, 0, 1,  0, 0,  0, 0, 11, 1,  0,  0, 0,            0, 0, 0,             0, 1, 0, 0, 0, 0});

    // Outputs while reset is held.
    #1;
    chk1("rst.sb_stall", sb_stall, 0);
    chk1("rst.mdu_ack", mdu_ack, 1);
    chk1("rst.rf_we", rf_we, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      check_vec(i, tv[i]);
    end

    // Starvation: hold entry loses four times, then wins with wb_freeze.
    @(negedge clk); clr_in();
    id_valid = 1; id_issue = 1; id_mdu_op = 1; id_r = 5'd3; id_r_we = 1;
    #1 chk1("cont.issue_stall", sb_stall, 0);
    @(negedge clk); clr_in();
    mdu_done = 1; mdu_addr = 5'd3; mdu_data = 32'hDEADBEEF;
    wb_we = 1; wb_addr = 5'd1; wb_data = 32'h100;
    #1 chk1("cont.ack", mdu_ack, 1);
    chk32("cont.waddr0", {27'd0, rf_waddr}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      mdu_done = 0;
      wb_data = 32'h100 + 32'(i);
      #1;
      chk1($sformatf("cont.freeze%0d", i), wb_freeze, 0);
      chk1($sformatf("cont.ack%0d", i), mdu_ack, 0);
      chk32($sformatf("cont.waddr%0d", i), {27'd0, rf_waddr}, 32'd1);
      chk32($sformatf("cont.wdata%0d", i), rf_wdata, 32'h100 + 32'(i));
    end
    @(negedge clk);
    id_valid = 1; id_x = 5'd3; id_x_re = 1;
    #1 chk1("cont.freeze5", wb_freeze, 1);
    chk1("cont.we5", rf_we, 1);
    chk32("cont.waddr5", {27'd0, rf_waddr}, 32'd3);
    chk32("cont.wdata5", rf_wdata, 32'hDEADBEEF);
    chk1("cont.stall5", sb_stall, 1);
    @(negedge clk);
    #1 chk1("cont.freeze6", wb_freeze, 0);
    chk32("cont.waddr6", {27'd0, rf_waddr}, 32'd1);
    chk1("cont.ack6", mdu_ack, 1);
    chk1("cont.stall6", sb_stall, 0);

    // Asynchronous reset in the middle of a held result.
    @(negedge clk); clr_in();
    id_valid = 1; id_issue = 1; id_mdu_op = 1; id_r = 5'd3; id_r_we = 1;
    @(negedge clk); clr_in();
    mdu_done = 1; mdu_addr = 5'd3; mdu_data = 32'h33; wb_we = 1; wb_addr = 5'd1;
    @(negedge clk); clr_in();
    wb_we = 1; wb_addr = 5'd1; id_valid = 1; id_x = 5'd3; id_x_re = 1;
    #1 chk1("rstm.ack_pre", mdu_ack, 0);
    chk1("rstm.stall_pre", sb_stall, 1);
    #1 rst_n = 1'b0; wb_we = 0;
    #1 chk1("rstm.ack", mdu_ack, 1);
    chk1("rstm.we", rf_we, 0);
    chk1("rstm.freeze", wb_freeze, 0);
    chk1("rstm.stall", sb_stall, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    #1 chk1("rstm.stall_post", sb_stall, 0);
    chk1("rstm.we_post", rf_we, 0);
    id_mdu_op = 1; id_r = 5'd12; id_r_we = 1;
    #1 chk1("rstm.mdu_stall_post", sb_stall, 0);

    // Back-to-back results on the depth-2 instance.
    @(negedge clk); clr_in();
    id_valid = 1; id_issue = 1; id_mdu_op = 1; id_r = 5'd4; id_r_we = 1;
    #1 chk1("b2b.iss4", sb_stall2, 0);
    @(negedge clk);
    id_r = 5'd8;
    #1 chk1("b2b.iss8", sb_stall2, 0);
    @(negedge clk); clr_in();
    id_valid = 1; id_mdu_op = 1; id_r = 5'd12; id_r_we = 1;
    mdu_done = 1; mdu_addr = 5'd4; mdu_data = 32'h44;
    wb_we = 1; wb_addr = 5'd1; wb_data = 32'h11;
    #1 chk1("b2b.full_stall", sb_stall2, 1);
    chk1("b2b.ack_c2", mdu_ack2, 1);
    chk32("b2b.waddr_c2", {27'd0, rf_waddr2}, 32'd1);
    @(negedge clk); clr_in();
    mdu_done = 1; mdu_addr = 5'd8; mdu_data = 32'h88;
    wb_we = 1; wb_addr = 5'd1; wb_data = 32'h12;
    #1 chk1("b2b.ack_c3", mdu_ack2, 0);
    chk32("b2b.wdata_c3", rf_wdata2, 32'h12);
    @(negedge clk);
    wb_we = 0; id_valid = 1; id_x = 5'd4; id_x_re = 1;
    #1 chk1("b2b.ack_c4", mdu_ack2, 0);
    chk1("b2b.we_c4", rf_we2, 1);
    chk32("b2b.waddr_c4", {27'd0, rf_waddr2}, 32'd4);
    chk32("b2b.wdata_c4", rf_wdata2, 32'h44);
    chk1("b2b.stall_c4", sb_stall2, 1);
    @(negedge clk);
    id_mdu_op = 1; id_r = 5'd12; id_r_we = 1;
    #1 chk1("b2b.stall_c5", sb_stall2, 0);
    chk1("b2b.ack_c5", mdu_ack2, 1);
    chk1("b2b.we_c5", rf_we2, 0);
    @(negedge clk); clr_in();
    id_valid = 1; id_x = 5'd8; id_x_re = 1;
    #1 chk1("b2b.stall_c6", sb_stall2, 1);
    chk32("b2b.waddr_c6", {27'd0, rf_waddr2}, 32'd8);
    chk32("b2b.wdata_c6", rf_wdata2, 32'h88);
    chk1("b2b.ack_c6", mdu_ack2, 0);
    @(negedge clk);
    id_issue = 1; id_mdu_op = 1; id_r = 5'd10; id_r_we = 1;
    #1 chk1("b2b.stall_c7", sb_stall2, 0);
    chk1("b2b.ack_c7", mdu_ack2, 1);
    chk1("b2b.we_c7", rf_we2, 0);
    @(negedge clk); clr_in();
    id_valid = 1; id_issue = 1; id_mdu_op = 1; id_r = 5'd11; id_r_we = 1;
    #1 chk1("b2b.stall_c8", sb_stall2, 0);
    @(negedge clk); clr_in();
    id_valid = 1; id_mdu_op = 1; id_r = 5'd13; id_r_we = 1;
    #1 chk1("b2b.stall_c9", sb_stall2, 1);

    @(negedge clk); clr_in();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
